// File: rtl/movavg_pkg.sv
// movavg_pkg: shared types and helpers for the streaming moving-average unit.
// Holds the FSM state encoding and the accumulator width calculation.
package movavg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Accumulator width that can hold the sum of n full-scale w-bit samples
  function automatic int accWidth(input int w, input int n);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/movavg_stream_if.sv
// movavg_stream_if: sample-in / average-out streaming bus with valid/ready
// handshakes on both sides. The slave modport is the averaging block, the
// master modport is whatever drives samples in and consumes averages.
interface movavg_stream_if #(
  parameter int W = 64
);

  logic [W-1:0] din;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dout;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  din,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output dout,
    output out_valid
  );

  modport master (
    output din,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  dout,
    input  out_valid
  );

endinterface

// File: rtl/movavg_tapline.sv
// movavg_tapline: history of the previous DEPTH samples for the moving average.
// tap[1] is the most recent completed sample; the line shifts by one on each
// output handshake. The read port returns tap[i_idx], or zero for an index
// outside 1..DEPTH. DEPTH=0 builds no storage and always reads zero.
module movavg_tapline #(
  parameter int W     = 64,
  parameter int DEPTH = 3,
  parameter int IW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_shift,
  input  logic [W-1:0]  i_din,
  input  logic [IW-1:0] i_idx,
  output logic [W-1:0]  o_tap
);

  if (DEPTH > 0) begin : g_taps
    logic [W-1:0] r_taps [1:DEPTH];

    // Shift the newest completed sample into tap[1]; clear on reset
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 1; k <= DEPTH; k++) begin
          r_taps[k] <= '0;
        end
      end else if (i_shift) begin
        r_taps[1] <= i_din;
        for (int k = 2; k <= DEPTH; k++) begin
          r_taps[k] <= r_taps[k-1];
        end
      end
    end

    // Indexed read port feeding the shared adder
    always_comb begin
      o_tap = '0;
      for (int k = 1; k <= DEPTH; k++) begin
        if (i_idx == IW'(k)) begin
          o_tap = r_taps[k];
        end
      end
    end
  end else begin : g_none
    assign o_tap = '0;
  end

endmodule

// File: rtl/movavg_stream.sv
// movavg_stream: streaming NTAPS-window moving average with one shared adder.
// A sample is accepted in IDLE, the stored taps are added one per cycle in
// ACCUM, and the average is held in DONE until the consumer takes it; only
// then does the tap line shift, so every sample is counted exactly once.
// Optional build macro MOVAVG_ROUND_EN: round-half-up divide with saturation
// instead of the default truncating divide.
module movavg_stream
  import movavg_pkg::*;
#(
  parameter int W     = 64,
  parameter int NTAPS = 4
) (
  input  logic            clk,
  input  logic            reset,
  movavg_stream_if.slave  io_bus
);

  localparam int LOG2N = $clog2(NTAPS);
  localparam int AW    = accWidth(W, NTAPS);
  localparam int IW    = (LOG2N > 0) ? LOG2N : 1;
  localparam int DEPTH = NTAPS - 1;

  state_t        r_state;
  state_t        w_nextState;
  logic [AW-1:0] r_acc;
  logic [W-1:0]  r_sreg;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  w_tap;
  logic [W-1:0]  w_quot;
  logic          w_outFire;
  logic          w_lastTap;

  assign w_outFire = (r_state == DONE) && io_bus.out_ready;
  assign w_lastTap = (r_idx == IW'(DEPTH));

  movavg_tapline #(
    .W     (W),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_tapline (
    .clk     (clk),
    .reset   (reset),
    .i_shift (w_outFire),
    .i_din   (r_sreg),
    .i_idx   (r_idx),
    .o_tap   (w_tap)
  );

  // State register; reset and any illegal encoding land in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs; dout is forced to zero outside DONE
  always_comb begin
    w_nextState      = r_state;
    io_bus.in_ready  = 1'b0;
    io_bus.out_valid = 1'b0;
    io_bus.dout      = '0;
    case (r_state)
      IDLE: begin
        io_bus.in_ready = 1'b1;
        if (io_bus.in_valid) begin
          w_nextState = (NTAPS == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (w_lastTap) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        io_bus.out_valid = 1'b1;
        io_bus.dout      = w_quot;
        if (io_bus.out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: load the new sample on accept, then add one tap per ACCUM cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_sreg <= '0;
      r_idx  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.in_valid) begin
            r_acc  <= AW'(io_bus.din);
            r_sreg <= io_bus.din;
            r_idx  <= IW'(1);
          end
        end
        ACCUM: begin
          r_acc <= r_acc + AW'(w_tap);
          r_idx <= r_idx + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MOVAVG_ROUND_EN
  if (LOG2N > 0) begin : g_round
    localparam int RW = AW + 1;
    logic [RW-1:0] w_rounded;
    logic [RW-1:0] w_shifted;
    // One extra bit keeps the half-LSB add from wrapping before the shift
    assign w_rounded = {1'b0, r_acc} + (RW'(1) << (LOG2N - 1));
    assign w_shifted = w_rounded >> LOG2N;
    assign w_quot    = ((w_shifted >> W) != '0) ? {W{1'b1}} : w_shifted[W-1:0];
  end else begin : g_single
    assign w_quot = r_acc[W-1:0];
  end
`else
  assign w_quot = W'(r_acc >> LOG2N);
`endif

endmodule

// File: doc/movavg_stream.md
Name: movavg_stream

Overview:
- Parametrised successor of the 64-bit, 4-tap sequential moving-average unit.
- Averages the newest input sample with the previous NTAPS-1 accepted samples, using one shared adder across multiple cycles.
- Adds valid/ready handshakes on input and output, overflow-free accumulation, and a power-of-two divide.
- Sits between a streaming sample source and a downstream consumer in the datapath.

Parameters:
- W, 64, sample and output data width in bits.
- NTAPS, 4, window length including the current sample; power of two, 1..256.
- LOG2N, $clog2(NTAPS), derived value; not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- din  in  W  input sample.
- in_valid  in  1  din is valid.
- in_ready  out  1  block can accept a sample.
- dout  out  W  window average.
- out_valid  out  1  dout is valid.
- out_ready  in  1  consumer accepts dout.

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, acc=0, every tap=0, sample register=0.
  - in_ready=1, out_valid=0, dout=0.
- Accumulator width is W+LOG2N, so no overflow is possible.
- dout = acc[W+LOG2N-1:LOG2N], i.e. truncating divide by NTAPS.
- dout is 0 whenever out_valid=0. This is required, not a don't-care.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: acc<=din (zero-extended), sreg<=din, idx<=1.
  - Go to ACCUM, or to DONE if NTAPS==1.
- ACCUM:
  - in_ready=0.
  - Each cycle: acc<=acc+tap[idx] (zero-extended), idx<=idx+1.
  - After adding tap[NTAPS-1], go to DONE.
  - Takes exactly NTAPS-1 cycles.
- DONE:
  - out_valid=1 and dout is driven.
  - dout and out_valid stay stable until out_ready=1.
  - On out_valid&out_ready: tap[1]<=sreg, tap[k]<=tap[k-1] for k=2..NTAPS-1, then go to IDLE.
  - A new sample is accepted no earlier than the following cycle. There is no bypass.
- Latency:
  - out_valid asserts NTAPS cycles after the accept edge.
  - Minimum sample period is NTAPS+1 cycles when out_ready is held high.
- in_valid is ignored outside IDLE. din is sampled only on the accept edge.
- The tap line updates only on output handshake. A sample is never counted twice or dropped.
- The first NTAPS-1 outputs after reset average against zero taps.
- Reset in any state, including mid-ACCUM or in DONE waiting on out_ready:
  - Next cycle is IDLE with all reset values.
  - The pending output is discarded and taps are cleared.
- Illegal state encoding recovers to IDLE next cycle.

Optional Feature:
- Macro: MOVAVG_ROUND_EN.
- Defined: dout = (acc + 2^(LOG2N-1)) >> LOG2N, round half up.
  - The rounding add is performed at W+LOG2N+1 bits, then saturated to 2^W-1.
  - NTAPS==1 is unaffected.
- Undefined: truncating divide as specified in Behaviour.

Decomposition:
- Package movavg_pkg holds:
  - state_t enum {IDLE, ACCUM, DONE}, 2-bit encoding.
  - Function computing accumulator width W+$clog2(N).
- Sub-module movavg_tapline(W, DEPTH=NTAPS-1) holds:
  - Tap register array with synchronous clear.
  - Shift-enable input and indexed read port tap[idx].
  - DEPTH=0 generates no storage.
- The top level keeps the FSM, accumulator, idx counter and output divide.

Test Plan:
- Basic window: W=16, NTAPS=4, out_ready=1; feed 4,8,12,16 after reset -> dout 1,3,6,10. Each out_valid is 4 cycles after its accept. in_ready is low for 4 cycles per sample.
- Full-scale: W=16, NTAPS=4; feed 0xFFFF six times -> dout 0x3FFF, 0x7FFF, 0xBFFF, 0xFFFF, 0xFFFF, 0xFFFF. No wrap.
- Backpressure: in DONE, hold out_ready=0 for 3 cycles while in_valid=1 with din=0x55 -> dout and out_valid stable, in_ready=0, no sample accepted. Release -> one output handshake, IDLE next cycle.
- Reset mid-operation: accept 100, then assert reset in the 2nd ACCUM cycle. Next feed 8 -> dout 2, proving taps were cleared and the stale result was discarded.
- Rounding, NTAPS=4, single sample 2 after reset -> dout 1 with MOVAVG_ROUND_EN, 0 without. Sample 0xFFFF at W=16 with rounding -> 0x4000.
- Degenerate NTAPS=1: feed 7 -> dout 7 one cycle after accept. Back-to-back samples run at one every 2 cycles.
